// File: rtl/signed_divider_if.sv
// signed_divider_if: start/done handshake, operand and result bundle for signed_divider
//   master: drives start, dividend, divisor; observes quotient, remainder, busy, done, dbz, ovf
//   slave:  the divider side of the same signals
interface signed_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;
    logic       ovf;
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dbz, ovf
    );
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dbz, ovf
    );
endinterface

// File: rtl/signed_divider.sv
// signed_divider: 8-bit / 4-bit signed restoring divider, quotient truncated toward zero
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of signed_divider_if (start/dividend/divisor in;
//              quotient/remainder/busy/done/dbz/ovf out)
module signed_divider (
    input logic         clk,
    input logic         rst,
    signed_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t     state, state_n;
    logic [7:0] q, q_n;
    logic [4:0] r, r_n;
    logic [3:0] d, d_n;
    logic [2:0] cnt, cnt_n;
    logic       sign_q, sign_q_n, sign_r, sign_r_n, zero_div, zero_div_n;
    logic [7:0] quotient, quotient_n;
    logic [3:0] remainder, remainder_n;
    logic       busy, busy_n, done, done_n, dbz, dbz_n, ovf, ovf_n;
    logic [7:0] a_mag;
    logic [3:0] b_mag;
    logic [5:0] rs, t;
    // magnitudes are unsigned, so |-128| = 128 and |-8| = 8 fit without overflow
    assign a_mag = bus.dividend[7] ? 8'(-bus.dividend) : bus.dividend;
    assign b_mag = bus.divisor[3] ? 4'(-bus.divisor) : bus.divisor;
    // shifted partial remainder with one spare bit so t[5] is the borrow
    assign rs = {r, q[7]};
    assign t  = rs - {2'b00, d};
    always_comb begin
        state_n     = state;
        q_n         = q;
        r_n         = r;
        d_n         = d;
        cnt_n       = cnt;
        sign_q_n    = sign_q;
        sign_r_n    = sign_r;
        zero_div_n  = zero_div;
        quotient_n  = quotient;
        remainder_n = remainder;
        busy_n      = busy;
        done_n      = 1'b0;
        dbz_n       = dbz;
        ovf_n       = ovf;
        case (state)
            IDLE: if (bus.start) begin
                zero_div_n = (bus.divisor == 4'd0);
                q_n        = a_mag;
                d_n        = b_mag;
                r_n        = 5'd0;
                cnt_n      = 3'd0;
                sign_q_n   = bus.dividend[7] ^ bus.divisor[3];
                sign_r_n   = bus.dividend[7];
                busy_n     = 1'b1;
                state_n    = (bus.divisor == 4'd0) ? FIX : CALC;
            end
            CALC: begin
                r_n     = t[5] ? rs[4:0] : t[4:0];
                q_n     = {q[6:0], ~t[5]};
                cnt_n   = cnt + 3'd1;
                state_n = (cnt == 3'd7) ? FIX : CALC;
            end
            FIX: begin
                quotient_n  = zero_div ? 8'd0 : (sign_q ? 8'(-q) : q);
                remainder_n = zero_div ? 4'd0 : (sign_r ? 4'(-r[3:0]) : r[3:0]);
                ovf_n       = !zero_div && (q == 8'h80) && !sign_q;
                dbz_n       = zero_div;
                done_n      = 1'b1;
                busy_n      = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            q         <= 8'd0;
            r         <= 5'd0;
            d         <= 4'd0;
            cnt       <= 3'd0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_div  <= 1'b0;
            quotient  <= 8'd0;
            remainder <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_n;
            q         <= q_n;
            r         <= r_n;
            d         <= d_n;
            cnt       <= cnt_n;
            sign_q    <= sign_q_n;
            sign_r    <= sign_r_n;
            zero_div  <= zero_div_n;
            quotient  <= quotient_n;
            remainder <= remainder_n;
            busy      <= busy_n;
            done      <= done_n;
            dbz       <= dbz_n;
            ovf       <= ovf_n;
        end
    end
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.dbz       = dbz;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed-vector self-checking bench for signed_divider
module tb_signed_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    signed_divider_if bus ();
    signed_divider dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 30);
    endtask
    task automatic check_result(input string tag, input logic [7:0] eq, input logic [3:0] er,
                                input logic ed, input logic eo);
        check({tag, "_q"}, bus.quotient, eq);
        check({tag, "_r"}, bus.remainder, er);
        check({tag, "_dbz"}, bus.dbz, ed);
        check({tag, "_ovf"}, bus.ovf, eo);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask
    task automatic do_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er,
                         input logic ed, input logic eo, input int lat);
        int n;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy_acc"}, bus.busy, 1'b1);
        wait_done(n);
        check({tag, "_lat"}, n, lat);
        check_result(tag, eq, er, ed, eo);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        check({tag, "_q_held"}, bus.quotient, eq);
    endtask
    initial begin
        int n;
        int seen;
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.dbz, bus.ovf}, 18'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("p100_p7", 8'd100, 4'd7, 8'h0E, 4'h2, 1'b0, 1'b0, 9);
        do_op("n100_p7", 8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0, 1'b0, 9);
        do_op("p100_n7", 8'd100, 4'h9, 8'hF2, 4'h2, 1'b0, 1'b0, 9);
        do_op("n100_n7", 8'h9C, 4'h9, 8'h0E, 4'hE, 1'b0, 1'b0, 9);
        do_op("n128_n1", 8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 9);
        do_op("n128_n8", 8'h80, 4'h8, 8'h10, 4'h0, 1'b0, 1'b0, 9);
        do_op("p5_p7", 8'd5, 4'd7, 8'h00, 4'h5, 1'b0, 1'b0, 9);
        do_op("p37_z", 8'd37, 4'd0, 8'h00, 4'h0, 1'b1, 1'b0, 1);
        do_op("p37_p5", 8'd37, 4'd5, 8'h07, 4'h2, 1'b0, 1'b0, 9);
        // start and operands disturbed mid-calculation, start held through done
        @(negedge clk);
        bus.dividend = 8'd100;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 8'hFB;
        bus.divisor  = 4'd3;
        wait_done(n);
        check("mid_lat", n, 6);
        check_result("mid", 8'h0E, 4'h2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", bus.busy, 1'b1);
        check("b2b_done_low", bus.done, 1'b0);
        wait_done(n);
        check("b2b_lat", n, 9);
        check_result("b2b", 8'hFF, 4'hE, 1'b0, 1'b0);
        // reset during iteration 4 aborts silently
        @(negedge clk);
        bus.dividend = 8'd100;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_outs", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.dbz, bus.ovf}, 18'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("midrst_no_done", seen, 0);
        do_op("p50_p3", 8'd50, 4'd3, 8'h10, 4'h2, 1'b0, 1'b0, 9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
